scroll_matriz: RTL and testbench

Upstream feeder for the 5x7 LED matrix column scanner. It holds a 5-column glyph and scrolls it right-to-left through a 5-column display window, one column per scroll step. After each glyph it inserts one blank spacer column and then repeats the glyph, or switches to a newly loaded one. The window drives the scanner's `coluna1`..`coluna5` inputs directly.

---
 rtl/scroll_matriz.sv | 108 ++++++++++
 tb/tb_scroll_matriz.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scroll_matriz.sv
// scroll_matriz: scrolls a 5x7 glyph right-to-left through a 5-column window with a blank spacer
module scroll_matriz #(
    parameter int DIV = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        carregar,
    input  logic [34:0] glifo,
    output logic [6:0]  coluna1,
    output logic [6:0]  coluna2,
    output logic [6:0]  coluna3,
    output logic [6:0]  coluna4,
    output logic [6:0]  coluna5,
    output logic        passo,
    output logic        ativo
);
    localparam int PW = $clog2(DIV);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic [34:0]   g_cur, g_next;
    logic          pend;
    logic          step, wrap;
    logic [6:0]    col_new;

    // step strobe, spacer wrap and the column entering at the right edge
    always_comb begin
        step    = (state == RUN) && enable && (pre == PW'(DIV - 1));
        wrap    = step && (idx == 3'd5);
        col_new = (idx == 3'd0) ? g_cur[6:0]   :
                  (idx == 3'd1) ? g_cur[13:7]  :
                  (idx == 3'd2) ? g_cur[20:14] :
                  (idx == 3'd3) ? g_cur[27:21] :
                  (idx == 3'd4) ? g_cur[34:28] : 7'h00;
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // the first load starts scrolling; only reset leaves RUN
    always_comb begin
        state_nx = state;
        if (state == IDLE && carregar)
            state_nx = RUN;
    end

    // status output
    always_comb begin
        ativo = (state == RUN);
    end

    // prescaler, window shift, column index and glyph queue
    always_ff @(posedge clock) begin
        if (reset) begin
            pre     <= '0;
            idx     <= '0;
            g_cur   <= '0;
            g_next  <= '0;
            pend    <= 1'b0;
            passo   <= 1'b0;
            coluna1 <= '0;
            coluna2 <= '0;
            coluna3 <= '0;
            coluna4 <= '0;
            coluna5 <= '0;
        end else begin
            passo <= step;
            if (state == IDLE) begin
                if (carregar) begin
                    g_cur <= glifo;
                    idx   <= '0;
                    pre   <= '0;
                    pend  <= 1'b0;
                end
            end else begin
                if (enable)
                    pre <= step ? '0 : pre + 1'b1;
                if (step) begin
                    coluna1 <= coluna2;
                    coluna2 <= coluna3;
                    coluna3 <= coluna4;
                    coluna4 <= coluna5;
                    coluna5 <= col_new;
                    idx     <= wrap ? 3'd0 : idx + 3'd1;
                end
                if (wrap) begin
                    if (carregar)
                        g_cur <= glifo;
                    else if (pend)
                        g_cur <= g_next;
                    pend <= 1'b0;
                end else if (carregar) begin
                    g_next <= glifo;
                    pend   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_scroll_matriz.sv
// tb_scroll_matriz: table vectors, hand sequences and a random run against a stream model
module tb_scroll_matriz;
    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset, enable, carregar;
    logic [34:0] glifo;
    logic [6:0]  coluna1, coluna2, coluna3, coluna4, coluna5;
    logic        passo, ativo;

    int n_checks = 0;
    int n_fail   = 0;

    scroll_matriz #(.DIV(DIV)) dut (
        .clock(clock), .reset(reset), .enable(enable), .carregar(carregar), .glifo(glifo),
        .coluna1(coluna1), .coluna2(coluna2), .coluna3(coluna3), .coluna4(coluna4),
        .coluna5(coluna5), .passo(passo), .ativo(ativo)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [34:0] pack(input logic [6:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    function automatic logic [34:0] win(input logic [6:0] a, b, c, d, e);
        return {a, b, c, d, e};
    endfunction

    // reference: counts enabled cycles and plays a stream of glyph columns and spacers
    logic [6:0]  mw [5];
    logic [34:0] mcur, mnxt;
    bit          running, mpend, mpasso;
    int          ecnt, nstep;

    task automatic model(input logic r, e, l, input logic [34:0] g);
        bit st, wr;
        int pos;
        if (r) begin
            running = 0; mpend = 0; mpasso = 0; ecnt = 0; nstep = 0; mcur = '0;
            for (int i = 0; i < 5; i++) mw[i] = '0;
        end else if (!running) begin
            mpasso = 0;
            if (l) begin
                running = 1; mcur = g; mpend = 0; ecnt = 0; nstep = 0;
            end
        end else begin
            st = e && ((ecnt + 1) % DIV == 0);
            if (e) ecnt++;
            mpasso = st;
            wr = 0;
            if (st) begin
                pos = nstep % 6;
                for (int i = 0; i < 4; i++) mw[i] = mw[i + 1];
                mw[4] = (pos < 5) ? 7'((mcur >> (7 * pos)) & 35'h7F) : 7'h00;
                nstep++;
                if (pos == 5) begin
                    wr = 1;
                    if (l) mcur = g;
                    else if (mpend) mcur = mnxt;
                    mpend = 0;
                end
            end
            if (l && !wr) begin
                mnxt = g;
                mpend = 1;
            end
        end
    endtask

    task automatic tick(input logic r, e, l, input logic [34:0] g);
        reset = r; enable = e; carregar = l; glifo = g;
        @(posedge clock);
        model(r, e, l, g);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic check(input string name, input logic [34:0] w, input logic ps, at);
        logic [34:0] got;
        got = {coluna1, coluna2, coluna3, coluna4, coluna5};
        n_checks++;
        if (got !== w || passo !== ps || ativo !== at) begin
            n_fail++;
            $display("FAIL %s: got win=%h passo=%b ativo=%b, expected win=%h passo=%b ativo=%b",
                     name, got, passo, ativo, w, ps, at);
        end
    endtask

    typedef struct {
        logic        r, e, l;
        logic [34:0] g;
        int          n;
        logic [34:0] w;
        logic        ps, at;
    } vec_t;

    vec_t tbl[$];

    logic [34:0] g1, g7f, g55, w1;
    logic [63:0] rg;

    initial begin
        reset = 1'b1; enable = 1'b0; carregar = 1'b0; glifo = '0;
        g1  = pack(7'h01, 7'h02, 7'h04, 7'h08, 7'h10);
        g7f = pack(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        g55 = pack(7'h55, 7'h55, 7'h55, 7'h55, 7'h55);

        tbl.push_back('{1, 1, 0, '0, 2, '0, 0, 0});
        tbl.push_back('{0, 1, 1, g1, 1, '0, 0, 1});
        tbl.push_back('{0, 1, 0, '0, 3, '0, 0, 1});
        tbl.push_back('{0, 1, 0, '0, 1, win(0, 0, 0, 0, 7'h01), 1, 1});
        tbl.push_back('{0, 1, 0, '0, 3, win(0, 0, 0, 0, 7'h01), 0, 1});
        tbl.push_back('{0, 1, 0, '0, 1, win(0, 0, 0, 7'h01, 7'h02), 1, 1});
        tbl.push_back('{0, 1, 0, '0, 4, win(0, 0, 7'h01, 7'h02, 7'h04), 1, 1});
        tbl.push_back('{0, 1, 0, '0, 4, win(0, 7'h01, 7'h02, 7'h04, 7'h08), 1, 1});
        tbl.push_back('{0, 1, 0, '0, 4, win(7'h01, 7'h02, 7'h04, 7'h08, 7'h10), 1, 1});
        tbl.push_back('{0, 1, 0, '0, 4, win(7'h02, 7'h04, 7'h08, 7'h10, 7'h00), 1, 1});
        tbl.push_back('{0, 1, 0, '0, 4, win(7'h04, 7'h08, 7'h10, 7'h00, 7'h01), 1, 1});

        foreach (tbl[i]) begin
            repeat (tbl[i].n) tick(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].g);
            check($sformatf("vec%0d", i), tbl[i].w, tbl[i].ps, tbl[i].at);
        end

        // queued load during step 3 appears after the spacer
        tick(1, 1, 0, '0); tick(1, 1, 0, '0);
        tick(0, 1, 1, g1);
        idle(11);
        tick(0, 1, 1, g7f);
        check("queue_step3", win(0, 0, 7'h01, 7'h02, 7'h04), 1, 1);
        idle(4);
        check("queue_step4", win(0, 7'h01, 7'h02, 7'h04, 7'h08), 1, 1);
        idle(8);
        check("queue_step6", win(7'h02, 7'h04, 7'h08, 7'h10, 7'h00), 1, 1);
        idle(4);
        check("queue_step7", win(7'h04, 7'h08, 7'h10, 7'h00, 7'h7F), 1, 1);

        // load on the wrap step beats a pending glyph
        tick(1, 1, 0, '0); tick(1, 1, 0, '0);
        tick(0, 1, 1, g1);
        idle(7);
        tick(0, 1, 1, g7f);
        idle(15);
        tick(0, 1, 1, g55);
        check("simul_step6", win(7'h02, 7'h04, 7'h08, 7'h10, 7'h00), 1, 1);
        idle(4);
        check("simul_step7", win(7'h04, 7'h08, 7'h10, 7'h00, 7'h55), 1, 1);
        idle(16);
        check("simul_step11", g55, 1, 1);

        // freeze mid-prescale then resume with the remaining count
        tick(1, 1, 0, '0); tick(1, 1, 0, '0);
        tick(0, 1, 1, g1);
        idle(6);
        w1 = win(0, 0, 0, 0, 7'h01);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 0, '0);
            check($sformatf("freeze%0d", i), w1, 0, 1);
        end
        idle(1);
        check("resume_wait", w1, 0, 1);
        idle(1);
        check("resume_step", win(0, 0, 0, 7'h01, 7'h02), 1, 1);

        // reset mid-scroll wins over enable and load
        tick(1, 1, 1, g55);
        check("reset_mid", '0, 0, 0);

        // random traffic against the stream model
        for (int i = 0; i < 3000; i++) begin
            rg = {$urandom(), $urandom()};
            tick(($urandom % 400) == 0, ($urandom % 5) != 0, ($urandom % 12) == 0, rg[34:0]);
            check($sformatf("rand%0d", i), {mw[0], mw[1], mw[2], mw[3], mw[4]}, mpasso, running);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
